// File: rtl/touch_spi_reader_pkg.sv
// Shared constants, FSM state type and helpers for the touch-panel SPI reader.
package touch_spi_reader_pkg;

  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  localparam int SCLK_PER_XFER     = 24;
  localparam int FIRST_SAMPLE_EDGE = 10;
  localparam int LAST_SAMPLE_EDGE  = 21;

  // Half-period boundaries counted from the chip-select falling edge:
  // odd boundaries are SCLK rising edges, even ones falling edges.
  localparam logic [5:0] HP_SAMPLE_FIRST = 6'(2 * FIRST_SAMPLE_EDGE - 1);
  localparam logic [5:0] HP_SAMPLE_LAST  = 6'(2 * LAST_SAMPLE_EDGE - 1);
  localparam logic [5:0] HP_CS_RISE      = 6'(2 * SCLK_PER_XFER + 1);
  localparam logic [5:0] HP_END          = 6'(2 * SCLK_PER_XFER + 2);

  typedef enum logic [2:0] {
    IDLE,
    XFER_X,
    GAP,
    XFER_Y,
    CALC,
    HOLD
  } state_e;

  function automatic logic [11:0] sat_sub12(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? a - b : 12'd0;
  endfunction

endpackage

// File: rtl/touch_spi_reader_spi_xfer24.sv
// One 24-SCLK mode-0 SPI transaction: 8-bit command out, 12-bit conversion result in.
module spi_xfer24
  import touch_spi_reader_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  cmd_i,
  input  logic        spi_miso_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] data_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  output logic        spi_cs_n_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  hp_q, hp_d, hp_next;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [11:0] data_q, data_d;

  // NOTE: every variable gets its hold value before the branches, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    div_d   = div_q;
    hp_d    = hp_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    hp_next = hp_q + 1'b1;

    if (!busy_q) begin
      if (start_i) begin
        busy_d = 1'b1;
        div_d  = '0;
        hp_d   = '0;
        cs_n_d = 1'b0;
        mosi_d = cmd_i[7];
        cmd_d  = {cmd_i[6:0], 1'b0};
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      hp_d  = hp_next;
      if (hp_next == HP_END) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (hp_next == HP_CS_RISE) begin
        cs_n_d = 1'b1;
      end else if (hp_next[0]) begin
        sclk_d = 1'b1;
        if (hp_next >= HP_SAMPLE_FIRST && hp_next <= HP_SAMPLE_LAST)
          data_d = {data_q[10:0], spi_miso_i};
      end else begin
        // Command bits drain out of cmd_q; zeros follow once it is empty.
        sclk_d = 1'b0;
        mosi_d = cmd_q[7];
        cmd_d  = {cmd_q[6:0], 1'b0};
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= '0;
      hp_q   <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      cmd_q  <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      div_q  <= div_d;
      hp_q   <= hp_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
      cmd_q  <= cmd_d;
      data_q <= data_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign data_o     = data_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;

endmodule

// File: rtl/touch_spi_reader.sv
// Pen-down polling of an XPT2046-class controller and raw-to-screen coordinate mapping.
module touch_spi_reader
  import touch_spi_reader_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int DEBOUNCE    = 50000,
  parameter int POLL_PERIOD = 500000,
  parameter int X_RAW_MIN   = 200,
  parameter int Y_RAW_MIN   = 200,
  parameter int X_SCALE     = 886,
  parameter int Y_SCALE     = 531,
  parameter int X_MAX       = 799,
  parameter int Y_MAX       = 479
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pen_irq_n,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic [10:0] gr_x,
  output logic [9:0]  gr_y,
  output logic        enable
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [8:0]    GAP_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [11:0]   X_MIN_C   = 12'(X_RAW_MIN);
  localparam logic [11:0]   Y_MIN_C   = 12'(Y_RAW_MIN);
  localparam logic [23:0]   X_SCALE_C = 24'(X_SCALE);
  localparam logic [23:0]   Y_SCALE_C = 24'(Y_SCALE);
  localparam logic [11:0]   X_MAX_C   = 12'(X_MAX);
  localparam logic [11:0]   Y_MAX_C   = 12'(Y_MAX);

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [DW-1:0]   deb_q, deb_d;
  logic            pen_down_q, pen_down_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [8:0]      step_q, step_d;
  logic [10:0]     gr_x_q, gr_x_d;
  logic [9:0]      gr_y_q, gr_y_d;
  logic            en_q, en_d;
  logic            xfer_start, xfer_busy, xfer_done, cap_x, cap_y;
  logic [7:0]      xfer_cmd;
  logic [11:0]     xfer_data, raw_x_q, raw_y_q, dx_q, dy_q, cx, cy;
  logic [23:0]     px_q, py_q;

  spi_xfer24 #(.CLK_DIV(CLK_DIV)) u_xfer (
    .clk        (clk),
    .reset      (reset),
    .start_i    (xfer_start),
    .cmd_i      (xfer_cmd),
    .spi_miso_i (spi_miso),
    .busy_o     (xfer_busy),
    .done_o     (xfer_done),
    .data_o     (xfer_data),
    .spi_sclk_o (spi_sclk),
    .spi_mosi_o (spi_mosi),
    .spi_cs_n_o (spi_cs_n)
  );

  // Debounce counts consecutive disagreeing samples; it is frozen while chip select is low.
  always_comb begin
    deb_d      = deb_q;
    pen_down_d = pen_down_q;
    if (spi_cs_n) begin
      if (!sync_q[1] == pen_down_q) begin
        deb_d = '0;
      end else if (deb_q == DEB_LAST) begin
        deb_d      = '0;
        pen_down_d = !sync_q[1];
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  assign cx = px_q[23:12];
  assign cy = py_q[23:12];

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_d     = (poll_q == POLL_LAST) ? poll_q : poll_q + 1'b1;
    en_d       = en_q & pen_down_q;
    gr_x_d     = gr_x_q;
    gr_y_d     = gr_y_q;
    xfer_start = 1'b0;
    xfer_cmd   = CMD_X;
    cap_x      = 1'b0;
    cap_y      = 1'b0;
    case (state_q)
      IDLE: if (pen_down_q && !xfer_busy) begin
        xfer_start = 1'b1;
        poll_d     = '0;
        state_d    = XFER_X;
      end
      XFER_X: if (xfer_done) begin
        cap_x   = 1'b1;
        step_d  = '0;
        state_d = pen_down_q ? GAP : IDLE;
      end
      GAP: begin
        if (!pen_down_q) begin
          state_d = IDLE;
        end else if (step_q == GAP_LAST) begin
          xfer_start = 1'b1;
          xfer_cmd   = CMD_Y;
          state_d    = XFER_Y;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      XFER_Y: if (xfer_done) begin
        cap_y   = 1'b1;
        step_d  = '0;
        state_d = CALC;
      end
      CALC: begin
        step_d = step_q + 1'b1;
        if (step_q == 9'd2) begin
          if (pen_down_q) begin
            gr_x_d  = (cx > X_MAX_C) ? X_MAX_C[10:0] : cx[10:0];
            gr_y_d  = (cy > Y_MAX_C) ? Y_MAX_C[9:0] : cy[9:0];
            en_d    = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: if (poll_q == POLL_LAST) begin
        if (pen_down_q) begin
          xfer_start = 1'b1;
          poll_d     = '0;
          state_d    = XFER_X;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      deb_q      <= '0;
      pen_down_q <= 1'b0;
      poll_q     <= '0;
      step_q     <= '0;
      gr_x_q     <= '0;
      gr_y_q     <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], pen_irq_n};
      deb_q      <= deb_d;
      pen_down_q <= pen_down_d;
      poll_q     <= poll_d;
      step_q     <= step_d;
      gr_x_q     <= gr_x_d;
      gr_y_q     <= gr_y_d;
      en_q       <= en_d;
    end
  end

  // NOTE: the arithmetic pipeline has no reset; its contents only matter in CALC after fresh captures.
  always_ff @(posedge clk) begin
    if (cap_x) raw_x_q <= xfer_data;
    if (cap_y) raw_y_q <= xfer_data;
    dx_q <= sat_sub12(raw_x_q, X_MIN_C);
    dy_q <= sat_sub12(raw_y_q, Y_MIN_C);
    px_q <= {12'd0, dx_q} * X_SCALE_C;
    py_q <= {12'd0, dy_q} * Y_SCALE_C;
  end

  assign gr_x   = gr_x_q;
  assign gr_y   = gr_y_q;
  assign enable = en_q;

endmodule

// File: tb/tb_touch_spi_reader.sv
// Directed bench for touch_spi_reader with an XPT2046-style MISO responder.
module tb_touch_spi_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pen_irq_n = 1'b1;
  logic        spi_miso = 1'b0;
  logic        spi_sclk, spi_mosi, spi_cs_n, enable;
  logic [10:0] gr_x;
  logic [9:0]  gr_y;

  int checks = 0;
  int errors = 0;

  logic [11:0] x_raw = 12'h800;
  logic [11:0] y_raw = 12'h800;
  logic [11:0] cur_raw;
  logic [7:0]  cmd_sh = 8'h00;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  int          cyc = 0, edge_cnt = 0, sclk_toggles = 0, mosi_errs = 0, cs_falls = 0, cur_fall = 0;
  logic [7:0]  cmd_log[$];
  int          xfalls[$];

  // POLL_PERIOD must exceed two 100-clk transfers plus gap and CALC at CLK_DIV=2.
  touch_spi_reader #(
    .CLK_DIV    (2),
    .DEBOUNCE   (4),
    .POLL_PERIOD(300)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pen_irq_n(pen_irq_n),
    .spi_miso (spi_miso),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs_n (spi_cs_n),
    .gr_x     (gr_x),
    .gr_y     (gr_y),
    .enable   (enable)
  );

  always #5 clk = ~clk;

  // Controller model: captures the command on rising edges, drives result bits after falling edges 9..20.
  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !spi_cs_n) begin
      cs_falls++;
      cur_fall = cyc;
      edge_cnt = 0;
      cmd_sh   = 8'h00;
    end
    if (spi_sclk != prev_sclk) sclk_toggles++;
    if (!prev_sclk && spi_sclk) begin
      edge_cnt++;
      if (edge_cnt <= 8) cmd_sh = {cmd_sh[6:0], spi_mosi};
      else if (spi_mosi) mosi_errs++;
      if (edge_cnt == 8) begin
        cmd_log.push_back(cmd_sh);
        if (cmd_sh == 8'hD0) xfalls.push_back(cur_fall);
      end
    end
    if (prev_sclk && !spi_sclk) begin
      cur_raw  = (cmd_sh == 8'hD0) ? x_raw : y_raw;
      spi_miso = (edge_cnt >= 9 && edge_cnt <= 20) ? cur_raw[20-edge_cnt] : 1'b0;
    end
    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
  end

  task automatic wait_next_poll(input string what);
    int  n = xfalls.size();
    bit  ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (xfalls.size() > n) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no X poll started, got %0d polls, expected %0d", what, xfalls.size(), n + 1);
    end
  endtask

  task automatic wait_enable(input string what);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: enable stayed %b, expected 1", what, enable);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_cs_n, spi_sclk, spi_mosi, enable} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: cs_n/sclk/mosi/enable = %b, expected 1000", {spi_cs_n, spi_sclk, spi_mosi, enable});
    end
    checks++;
    if (gr_x !== 11'd0 || gr_y !== 10'd0) begin
      errors++;
      $display("FAIL reset_coord: gr_x=%0d gr_y=%0d, expected 0 0", gr_x, gr_y);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (sclk_toggles != 0 || cs_falls != 0) begin
      errors++;
      $display("FAIL reset_idle: sclk toggles %0d cs falls %0d, expected 0 0", sclk_toggles, cs_falls);
    end
  endtask

  task automatic test_single_touch();
    x_raw = 12'h800;
    y_raw = 12'h800;
    pen_irq_n = 1'b0;
    wait_enable("single_enable");
    checks++;
    if (gr_x !== 11'd399 || gr_y !== 10'd239) begin
      errors++;
      $display("FAIL single_coord: gr_x=%0d gr_y=%0d, expected 399 239", gr_x, gr_y);
    end
    checks++;
    if (cmd_log.size() < 2 || cmd_log[0] !== 8'hD0 || cmd_log[1] !== 8'h90) begin
      errors++;
      $display("FAIL single_cmds: %0d commands logged, first two %h %h, expected d0 90",
               cmd_log.size(), (cmd_log.size() > 0) ? cmd_log[0] : 8'hxx, (cmd_log.size() > 1) ? cmd_log[1] : 8'hxx);
    end
    checks++;
    if (cs_falls != 2 || mosi_errs != 0) begin
      errors++;
      $display("FAIL single_framing: cs falls %0d mosi errors %0d, expected 2 0", cs_falls, mosi_errs);
    end
  endtask

  task automatic test_clamp();
    x_raw = 12'h0A0;
    y_raw = 12'hFFF;
    wait_next_poll("clamp_poll");
    repeat (230) @(negedge clk);
    checks++;
    if (gr_x !== 11'd0 || gr_y !== 10'd479 || enable !== 1'b1) begin
      errors++;
      $display("FAIL clamp: gr_x=%0d gr_y=%0d enable=%b, expected 0 479 1", gr_x, gr_y, enable);
    end
  endtask

  task automatic test_release_hold();
    int n;
    pen_irq_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (enable !== 1'b1) begin
      errors++;
      $display("FAIL release_early: enable=%b after 6 clk, expected 1", enable);
    end
    @(negedge clk);
    checks++;
    if (enable !== 1'b0 || gr_x !== 11'd0 || gr_y !== 10'd479) begin
      errors++;
      $display("FAIL release_drop: enable=%b gr_x=%0d gr_y=%0d, expected 0 0 479", enable, gr_x, gr_y);
    end
    n = cs_falls;
    repeat (400) @(negedge clk);
    checks++;
    if (cs_falls != n) begin
      errors++;
      $display("FAIL release_idle: cs falls %0d, expected %0d", cs_falls, n);
    end
  endtask

  task automatic test_glitch();
    int n = cs_falls;
    pen_irq_n = 1'b0;
    repeat (3) @(negedge clk);
    pen_irq_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (cs_falls != n || spi_cs_n !== 1'b1 || enable !== 1'b0) begin
      errors++;
      $display("FAIL glitch: cs falls %0d cs_n=%b enable=%b, expected %0d 1 0", cs_falls, spi_cs_n, enable, n);
    end
  endtask

  task automatic test_polling();
    logic [11:0] raws[3] = '{12'hE74, 12'hFFF, 12'h0C8};
    logic [10:0] exps[3] = '{11'd757, 11'd799, 11'd0};
    int base;
    x_raw = 12'h400;
    y_raw = 12'h800;
    pen_irq_n = 1'b0;
    wait_enable("poll_enable");
    base = xfalls.size() - 1;
    checks++;
    if (gr_x !== 11'd178 || gr_y !== 10'd239) begin
      errors++;
      $display("FAIL poll_first: gr_x=%0d gr_y=%0d, expected 178 239", gr_x, gr_y);
    end
    for (int i = 0; i < 3; i++) begin
      x_raw = raws[i];
      wait_next_poll("poll_next");
      repeat (230) @(negedge clk);
      checks++;
      if (gr_x !== exps[i]) begin
        errors++;
        $display("FAIL poll_track_%0d: gr_x=%0d, expected %0d", i, gr_x, exps[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (base < 0 || xfalls.size() < base + 4 || xfalls[base+i] - xfalls[base+i-1] != 300) begin
        errors++;
        $display("FAIL poll_period_%0d: spacing %0d clk, expected 300", i,
                 (base >= 0 && xfalls.size() >= base + 4) ? xfalls[base+i] - xfalls[base+i-1] : -1);
      end
    end
  endtask

  task automatic test_release_mid_y();
    bit ok = 1'b0;
    int n;
    x_raw = 12'h800;
    wait_next_poll("midy_poll");
    repeat (150) @(negedge clk);
    pen_irq_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (spi_cs_n === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midy_csrise: cs_n=%b, expected 1", spi_cs_n);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (enable !== 1'b0 || gr_x !== 11'd0 || gr_y !== 10'd239) begin
      errors++;
      $display("FAIL midy_discard: enable=%b gr_x=%0d gr_y=%0d, expected 0 0 239", enable, gr_x, gr_y);
    end
    n = cs_falls;
    repeat (400) @(negedge clk);
    checks++;
    if (cs_falls != n) begin
      errors++;
      $display("FAIL midy_idle: cs falls %0d, expected %0d", cs_falls, n);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int t;
    x_raw = 12'h800;
    y_raw = 12'h800;
    pen_irq_n = 1'b0;
    wait_enable("rst_enable");
    checks++;
    if (gr_x !== 11'd399 || gr_y !== 10'd239) begin
      errors++;
      $display("FAIL rst_pre: gr_x=%0d gr_y=%0d, expected 399 239", gr_x, gr_y);
    end
    wait_next_poll("rst_poll");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({spi_cs_n, spi_sclk, enable} !== 3'b100 || gr_x !== 11'd0 || gr_y !== 10'd0) begin
      errors++;
      $display("FAIL rst_async: cs_n/sclk/enable=%b gr_x=%0d gr_y=%0d, expected 100 0 0",
               {spi_cs_n, spi_sclk, enable}, gr_x, gr_y);
    end
    pen_irq_n = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    t = sclk_toggles;
    repeat (100) @(negedge clk);
    checks++;
    if (sclk_toggles != t || spi_cs_n !== 1'b1 || enable !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: sclk toggles %0d cs_n=%b enable=%b, expected %0d 1 0", sclk_toggles, spi_cs_n, enable, t);
    end
  endtask

  initial begin
    test_reset();
    test_single_touch();
    test_clamp();
    test_release_hold();
    test_glitch();
    test_polling();
    test_release_mid_y();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
